// File: rtl/pim_bus_slave.sv
// pim_bus_slave: PIM register window with command and result FIFOs (optional irq via PIM_BUS_SLAVE_IRQ_EN)
module pim_bus_slave #(
  parameter logic [31:0] PIM_CTRL         = 32'h4000_0010,
  parameter logic [31:0] PIM_R            = 32'h4000_0020,
  parameter logic [31:0] PIM_W_WEIGHT     = 32'h4000_0040,
  parameter logic [31:0] PIM_W_ACTIVATION = 32'h4000_0080,
  parameter int          CMD_DEPTH        = 4,
  parameter int          RES_DEPTH        = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_bus_addr,
  input  logic        i_bus_write,
  input  logic        i_bus_read,
  input  logic [3:0]  i_bus_size,
  input  logic [31:0] i_bus_wr_data,
  output logic [31:0] o_bus_rd_data,
  output logic        o_pim_cmd_valid,
  output logic        o_pim_cmd_type,
  output logic [3:0]  o_pim_cmd_sel,
  output logic [31:0] o_pim_cmd_data,
  input  logic        i_pim_cmd_ready,
  input  logic        i_pim_core_busy,
  input  logic        i_pim_res_valid,
  input  logic [31:0] i_pim_res_data,
  output logic        o_pim_res_ready
`ifdef PIM_BUS_SLAVE_IRQ_EN
  ,output logic       o_irq
`endif
);
  localparam int CW = $clog2(CMD_DEPTH);
  localparam int RW = $clog2(RES_DEPTH);
  logic [36:0] r_cmd_mem [CMD_DEPTH];
  logic [31:0] r_res_mem [RES_DEPTH];
  logic [CW-1:0] r_cmd_wp, r_cmd_rp;
  logic [RW-1:0] r_res_wp, r_res_rp;
  logic [CW:0] r_cmd_cnt, w_cmd_cnt_nx;
  logic [RW:0] r_res_cnt, w_res_cnt_nx;
  logic r_ovf, r_udf, r_szerr, r_res_ready, w_irq_en;
  logic [31:0] r_rd_data, w_status;
  logic w_wr, w_rd, w_ctrl_hit, w_res_hit, w_wgt_hit, w_act_hit, w_flush, w_clr;
  logic w_cmd_full, w_cmd_pop, w_cmd_req, w_cmd_push;
  logic w_res_empty, w_res_full, w_res_rd, w_res_pop, w_res_push;
  // a simultaneous write and read is a write; the read is ignored so read data holds
  assign w_wr       = i_bus_write;
  assign w_rd       = i_bus_read & ~i_bus_write;
  assign w_ctrl_hit = i_bus_addr == PIM_CTRL;
  assign w_res_hit  = i_bus_addr == PIM_R;
  assign w_wgt_hit  = (i_bus_addr & ~32'hF) == PIM_W_WEIGHT;
  assign w_act_hit  = (i_bus_addr & ~32'hF) == PIM_W_ACTIVATION;
  assign w_flush    = w_wr & w_ctrl_hit & i_bus_wr_data[0];
  assign w_clr      = w_wr & w_ctrl_hit & i_bus_wr_data[1];
  assign w_cmd_full = r_cmd_cnt == (CW+1)'(CMD_DEPTH);
  assign w_cmd_pop  = o_pim_cmd_valid & i_pim_cmd_ready;
  assign w_cmd_req  = w_wr & (w_wgt_hit | w_act_hit) & (i_bus_size == 4'hF);
  assign w_cmd_push = w_cmd_req & (~w_cmd_full | w_cmd_pop);
  assign w_res_empty = r_res_cnt == '0;
  assign w_res_full  = r_res_cnt == (RW+1)'(RES_DEPTH);
  assign w_res_rd    = w_rd & w_res_hit;
  assign w_res_pop   = w_res_rd & ~w_res_empty;
  // a full result FIFO still accepts a word when the bus pops in the same cycle
  assign w_res_push  = i_pim_res_valid & (~w_res_full | w_res_pop);
  assign w_cmd_cnt_nx = w_flush ? '0 : r_cmd_cnt + (CW+1)'(w_cmd_push) - (CW+1)'(w_cmd_pop);
  assign w_res_cnt_nx = w_flush ? '0 : r_res_cnt + (RW+1)'(w_res_push) - (RW+1)'(w_res_pop);
  assign o_pim_cmd_valid = r_cmd_cnt != '0;
  assign {o_pim_cmd_type, o_pim_cmd_sel, o_pim_cmd_data} = o_pim_cmd_valid ? r_cmd_mem[r_cmd_rp] : 37'd0;
  assign o_pim_res_ready = r_res_ready;
  assign o_bus_rd_data   = r_rd_data;
  assign w_status = {15'd0, w_irq_en, 4'(r_cmd_cnt), 4'(r_res_cnt), 3'd0,
                     r_szerr, r_udf, r_ovf, ~w_res_empty, o_pim_cmd_valid | i_pim_core_busy};
  always_ff @(posedge i_clk) begin
    if (w_cmd_push && !w_flush) r_cmd_mem[r_cmd_wp] <= {w_act_hit, i_bus_addr[3:0], i_bus_wr_data};
    if (w_res_push && !w_flush) r_res_mem[r_res_wp] <= i_pim_res_data;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd_wp    <= '0;
      r_cmd_rp    <= '0;
      r_cmd_cnt   <= '0;
      r_res_wp    <= '0;
      r_res_rp    <= '0;
      r_res_cnt   <= '0;
      r_res_ready <= 1'b1;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_szerr     <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_cmd_cnt   <= w_cmd_cnt_nx;
      r_res_cnt   <= w_res_cnt_nx;
      r_res_ready <= w_res_cnt_nx != (RW+1)'(RES_DEPTH);
      if (w_flush) begin
        r_cmd_wp <= '0;
        r_cmd_rp <= '0;
        r_res_wp <= '0;
        r_res_rp <= '0;
      end else begin
        if (w_cmd_push) r_cmd_wp <= r_cmd_wp + 1'b1;
        if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + 1'b1;
        if (w_res_push) r_res_wp <= r_res_wp + 1'b1;
        if (w_res_pop)  r_res_rp <= r_res_rp + 1'b1;
      end
      if (w_clr) begin
        r_ovf   <= 1'b0;
        r_udf   <= 1'b0;
        r_szerr <= 1'b0;
      end else begin
        if (w_cmd_req && w_cmd_full && !w_cmd_pop) r_ovf <= 1'b1;
        if (w_res_rd && w_res_empty) r_udf <= 1'b1;
        if (w_wr && (w_wgt_hit || w_act_hit) && i_bus_size != 4'hF) r_szerr <= 1'b1;
      end
      if (w_rd) r_rd_data <= w_ctrl_hit ? w_status : w_res_pop ? r_res_mem[r_res_rp] : '0;
    end
  end
`ifdef PIM_BUS_SLAVE_IRQ_EN
  logic r_irq_en, r_irq;
  assign w_irq_en = r_irq_en;
  assign o_irq    = r_irq;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && w_ctrl_hit) r_irq_en <= i_bus_wr_data[8];
      r_irq <= r_irq_en & (~w_res_empty | r_ovf | r_udf | r_szerr);
    end
  end
`else
  assign w_irq_en = 1'b0;
`endif
endmodule

// File: tb/tb_pim_bus_slave.sv
// tb_pim_bus_slave: directed self-checking bench for pim_bus_slave
module tb_pim_bus_slave;
  localparam logic [31:0] CTRL = 32'h4000_0010;
  localparam logic [31:0] RES  = 32'h4000_0020;
  logic        i_clk = 0, i_rst_n = 0;
  logic [31:0] i_bus_addr = 0, i_bus_wr_data = 0, i_pim_res_data = 0;
  logic        i_bus_write = 0, i_bus_read = 0, i_pim_cmd_ready = 0, i_pim_core_busy = 0, i_pim_res_valid = 0;
  logic [3:0]  i_bus_size = 4'hF;
  logic [31:0] o_bus_rd_data, o_pim_cmd_data;
  logic        o_pim_cmd_valid, o_pim_cmd_type, o_pim_res_ready;
  logic [3:0]  o_pim_cmd_sel;
`ifdef PIM_BUS_SLAVE_IRQ_EN
  logic        o_irq;
`endif
  int total = 0, bad = 0;
  logic [31:0] rd;
  pim_bus_slave dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_bus_addr(i_bus_addr), .i_bus_write(i_bus_write),
    .i_bus_read(i_bus_read), .i_bus_size(i_bus_size), .i_bus_wr_data(i_bus_wr_data),
    .o_bus_rd_data(o_bus_rd_data), .o_pim_cmd_valid(o_pim_cmd_valid), .o_pim_cmd_type(o_pim_cmd_type),
    .o_pim_cmd_sel(o_pim_cmd_sel), .o_pim_cmd_data(o_pim_cmd_data), .i_pim_cmd_ready(i_pim_cmd_ready),
    .i_pim_core_busy(i_pim_core_busy), .i_pim_res_valid(i_pim_res_valid), .i_pim_res_data(i_pim_res_data),
    .o_pim_res_ready(o_pim_res_ready)
`ifdef PIM_BUS_SLAVE_IRQ_EN
    , .o_irq(o_irq)
`endif
  );
  always #5 i_clk = ~i_clk;
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge i_clk);
    i_bus_addr = a; i_bus_wr_data = d; i_bus_size = s; i_bus_write = 1;
    @(negedge i_clk);
    i_bus_write = 0; i_bus_size = 4'hF;
  endtask
  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge i_clk);
    i_bus_addr = a; i_bus_read = 1;
    @(negedge i_clk);
    i_bus_read = 0;
    d = o_bus_rd_data;
  endtask
  task automatic res_push(input logic [31:0] d);
    @(negedge i_clk);
    i_pim_res_valid = 1; i_pim_res_data = d;
    @(negedge i_clk);
    i_pim_res_valid = 0;
  endtask
  task automatic test_reset;
    total++; if (o_bus_rd_data !== 0) begin bad++; $display("FAIL reset_rd got=%h exp=0", o_bus_rd_data); end
    total++; if (o_pim_cmd_valid !== 0 || o_pim_cmd_sel !== 0 || o_pim_cmd_data !== 0 || o_pim_cmd_type !== 0) begin
      bad++; $display("FAIL reset_cmd got=%b/%h/%h exp=0", o_pim_cmd_valid, o_pim_cmd_sel, o_pim_cmd_data); end
    total++; if (o_pim_res_ready !== 1) begin bad++; $display("FAIL reset_res_ready got=%b exp=1", o_pim_res_ready); end
    bus_rd(CTRL, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", rd); end
  endtask
  task automatic test_weight;
    bus_wr(32'h4000_0043, 32'hDEAD_BEEF, 4'hF);
    total++; if ({o_pim_cmd_valid, o_pim_cmd_type, o_pim_cmd_sel, o_pim_cmd_data} !== {1'b1, 1'b0, 4'd3, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL wgt_head got=%b/%b/%h/%h exp=1/0/3/deadbeef", o_pim_cmd_valid, o_pim_cmd_type, o_pim_cmd_sel, o_pim_cmd_data); end
    bus_rd(CTRL, rd);
    total++; if (rd !== 32'h0000_1001) begin bad++; $display("FAIL wgt_status got=%h exp=00001001", rd); end
    @(negedge i_clk); i_pim_cmd_ready = 1;
    @(negedge i_clk); i_pim_cmd_ready = 0;
    total++; if (o_pim_cmd_valid !== 0) begin bad++; $display("FAIL wgt_pop got=%b exp=0", o_pim_cmd_valid); end
  endtask
  task automatic test_overflow;
    for (int i = 0; i < 5; i++) bus_wr(32'h4000_0081, 32'(i + 1), 4'hF);
    bus_rd(CTRL, rd);
    total++; if (rd !== 32'h0000_4005) begin bad++; $display("FAIL ovf_status got=%h exp=00004005", rd); end
    i_pim_cmd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      total++; if ({o_pim_cmd_valid, o_pim_cmd_type, o_pim_cmd_sel, o_pim_cmd_data} !== {1'b1, 1'b1, 4'd1, 32'(i + 1)}) begin
        bad++; $display("FAIL ovf_pop%0d got=%b/%b/%h/%h exp=1/1/1/%h", i, o_pim_cmd_valid, o_pim_cmd_type, o_pim_cmd_sel, o_pim_cmd_data, i + 1); end
      @(negedge i_clk);
    end
    i_pim_cmd_ready = 0;
    total++; if (o_pim_cmd_valid !== 0) begin bad++; $display("FAIL ovf_drained got=%b exp=0", o_pim_cmd_valid); end
    bus_wr(CTRL, 32'h2, 4'hF);
    bus_rd(CTRL, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL ovf_clear got=%h exp=0", rd); end
  endtask
  task automatic test_result;
    res_push(32'h11);
    res_push(32'h22);
    bus_rd(RES, rd);
    total++; if (rd !== 32'h11) begin bad++; $display("FAIL res_pop0 got=%h exp=11", rd); end
    bus_rd(RES, rd);
    total++; if (rd !== 32'h22) begin bad++; $display("FAIL res_pop1 got=%h exp=22", rd); end
    bus_rd(RES, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL res_empty got=%h exp=0", rd); end
    bus_rd(CTRL, rd);
    total++; if (rd !== 32'h0000_0008) begin bad++; $display("FAIL res_udf got=%h exp=00000008", rd); end
    bus_wr(CTRL, 32'h2, 4'hF);
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) res_push(32'hA0 + 32'(i));
    total++; if (o_pim_res_ready !== 0) begin bad++; $display("FAIL full_ready got=%b exp=0", o_pim_res_ready); end
    bus_rd(CTRL, rd);
    total++; if (rd !== 32'h0000_0402) begin bad++; $display("FAIL full_status got=%h exp=00000402", rd); end
    @(negedge i_clk);
    i_bus_addr = RES; i_bus_read = 1; i_pim_res_valid = 1; i_pim_res_data = 32'hA4;
    @(negedge i_clk);
    i_bus_read = 0; i_pim_res_valid = 0;
    total++; if (o_bus_rd_data !== 32'hA0) begin bad++; $display("FAIL popush_data got=%h exp=a0", o_bus_rd_data); end
    bus_rd(CTRL, rd);
    total++; if (rd !== 32'h0000_0402) begin bad++; $display("FAIL popush_count got=%h exp=00000402", rd); end
    for (int i = 1; i < 5; i++) begin
      bus_rd(RES, rd);
      total++; if (rd !== 32'hA0 + 32'(i)) begin bad++; $display("FAIL popush_drain%0d got=%h exp=%h", i, rd, 32'hA0 + i); end
    end
    total++; if (o_pim_res_ready !== 1) begin bad++; $display("FAIL drained_ready got=%b exp=1", o_pim_res_ready); end
  endtask
  task automatic test_decode;
    bus_wr(32'h4000_004F, 32'h1234_5678, 4'hF);
    bus_rd(CTRL, rd);
    total++; if (rd !== 32'h0000_1001) begin bad++; $display("FAIL dec_status got=%h exp=00001001", rd); end
    @(negedge i_clk);
    i_bus_addr = CTRL; i_bus_wr_data = 0; i_bus_write = 1; i_bus_read = 1;
    @(negedge i_clk);
    i_bus_write = 0; i_bus_read = 0;
    total++; if (o_bus_rd_data !== 32'h0000_1001) begin bad++; $display("FAIL wr_rd_hold got=%h exp=00001001", o_bus_rd_data); end
    bus_rd(32'h4000_0030, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL unmapped got=%h exp=0", rd); end
    i_pim_core_busy = 1;
    total++; if (o_pim_cmd_sel !== 4'hF || o_pim_cmd_data !== 32'h1234_5678) begin
      bad++; $display("FAIL dec_sel got=%h/%h exp=f/12345678", o_pim_cmd_sel, o_pim_cmd_data); end
    @(negedge i_clk); i_pim_cmd_ready = 1;
    @(negedge i_clk); i_pim_cmd_ready = 0;
    bus_rd(CTRL, rd);
    total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL core_busy got=%h exp=00000001", rd); end
    i_pim_core_busy = 0;
  endtask
  task automatic test_size_flush;
    bus_wr(32'h4000_0040, 32'hCAFE, 4'b0011);
    total++; if (o_pim_cmd_valid !== 0) begin bad++; $display("FAIL size_nopush got=%b exp=0", o_pim_cmd_valid); end
    bus_rd(CTRL, rd);
    total++; if (rd !== 32'h0000_0010) begin bad++; $display("FAIL size_err got=%h exp=00000010", rd); end
    bus_wr(32'h4000_0042, 32'hBEEF, 4'hF);
    res_push(32'h55);
    bus_rd(CTRL, rd);
    total++; if (rd !== 32'h0000_1113) begin bad++; $display("FAIL preflush got=%h exp=00001113", rd); end
    bus_wr(CTRL, 32'h3, 4'hF);
    bus_rd(CTRL, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL flush got=%h exp=0", rd); end
    total++; if (o_pim_cmd_valid !== 0) begin bad++; $display("FAIL flush_cmd got=%b exp=0", o_pim_cmd_valid); end
  endtask
  task automatic test_async_reset;
    bus_wr(32'h4000_0085, 32'h77, 4'hF);
    for (int i = 0; i < 4; i++) res_push(32'h90 + 32'(i));
    bus_rd(CTRL, rd);
    total++; if (rd !== 32'h0000_1403) begin bad++; $display("FAIL prereset got=%h exp=00001403", rd); end
    #3 i_rst_n = 0;
    #1;
    total++; if (o_bus_rd_data !== 0 || o_pim_cmd_valid !== 0 || o_pim_cmd_sel !== 0 || o_pim_cmd_data !== 0 || o_pim_cmd_type !== 0) begin
      bad++; $display("FAIL async_rst got=%h/%b/%h/%h exp=0", o_bus_rd_data, o_pim_cmd_valid, o_pim_cmd_sel, o_pim_cmd_data); end
    total++; if (o_pim_res_ready !== 1) begin bad++; $display("FAIL async_rst_ready got=%b exp=1", o_pim_res_ready); end
    @(negedge i_clk); i_rst_n = 1;
    bus_rd(CTRL, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL post_reset got=%h exp=0", rd); end
  endtask
  initial begin
    #12 i_rst_n = 1;
    test_reset;
    test_weight;
    test_overflow;
    test_result;
    test_back_to_back;
    test_decode;
    test_size_flush;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pim_bus_slave.md
Name: pim_bus_slave

Overview:
- Memory-mapped bus responder sitting in front of the PIM macro. It serves the PIM register window that the PIM DMA and the CPU access.
- Decodes status/control, result-read and weight/activation write addresses. Buffers weight/activation words toward the PIM core in a command FIFO and buffers PIM results in a result FIFO.
- Returns registered read data with one-cycle latency. This matches initiators that sample read data in the cycle after the read strobe.

Parameters:
- PIM_CTRL, 32'h4000_0010, status/control register address (exact match)
- PIM_R, 32'h4000_0020, result pop address (exact match)
- PIM_W_WEIGHT, 32'h4000_0040, weight write base; addr[3:0] = PIM select
- PIM_W_ACTIVATION, 32'h4000_0080, activation write base; addr[3:0] = PIM select
- CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2)
- RES_DEPTH, 4, result FIFO entries (power of 2, ≥2)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_bus_addr  in  32  bus address
- i_bus_write  in  1  write strobe
- i_bus_read  in  1  read strobe
- i_bus_size  in  4  byte enables
- i_bus_wr_data  in  32  write data
- o_bus_rd_data  out  32  registered read data
- o_pim_cmd_valid  out  1  command FIFO head valid
- o_pim_cmd_type  out  1  0 = weight, 1 = activation
- o_pim_cmd_sel  out  4  PIM select
- o_pim_cmd_data  out  32  command data
- i_pim_cmd_ready  in  1  core accepts head
- i_pim_core_busy  in  1  core computing
- i_pim_res_valid  in  1  core presents result
- i_pim_res_data  in  32  result word
- o_pim_res_ready  out  1  result FIFO not full

Behaviour:
- Reset: clock/reset per "Already decided": one clock i_clk; reset i_rst_n, asynchronous, active-low.
  - o_bus_rd_data = 0; both FIFOs empty; sticky flags cleared.
  - o_pim_cmd_valid = 0 and cmd type/sel/data = 0 while empty.
  - o_pim_res_ready = 1.
- Address decode:
  - ctrl hit: addr == PIM_CTRL.
  - res hit: addr == PIM_R.
  - wgt hit: (addr & ~32'hF) == PIM_W_WEIGHT.
  - act hit: (addr & ~32'hF) == PIM_W_ACTIVATION.
  - Any other address: no effect; a read of it returns 0.
- Strobe priority: write and read asserted in the same cycle is treated as write only; o_bus_rd_data holds.
- Status word returned on a PIM_CTRL read:
  - [0] busy = cmd FIFO non-empty OR i_pim_core_busy
  - [1] data_valid = result FIFO non-empty
  - [2] overflow sticky
  - [3] underflow sticky
  - [4] size error sticky
  - [11:8] result count
  - [15:12] cmd count
  - all other bits 0
  - Status reflects state at the strobe edge.
- Read latency: read strobe in cycle N gives o_bus_rd_data valid from N+1 and held until the next read.
- Weight/activation write:
  - Requires i_bus_size == 4'b1111; otherwise the write is dropped and size error is set.
  - Accepted write pushes {type, addr[3:0], data}.
  - Push while full (after counting a same-cycle pop) is dropped and sets overflow.
- Command output:
  - The head is presented combinationally from the FIFO.
  - Pop when o_pim_cmd_valid && i_pim_cmd_ready.
  - Push into a full FIFO with a same-cycle pop succeeds.
  - Push into an empty FIFO is visible the next cycle.
- Result input:
  - Push when i_pim_res_valid && o_pim_res_ready.
  - A full FIFO drops ready; push while full with a same-cycle pop is allowed, and ready stays low that cycle (registered).
- PIM_R read:
  - Pops the result head into o_bus_rd_data.
  - On empty, returns 0 and sets underflow.
  - Pop and push in the same cycle: count unchanged; returned data is the old head.
- PIM_CTRL write:
  - bit0 = 1: flushes both FIFOs.
  - bit1 = 1: clears the sticky flags.
  - Flush has priority over same-cycle push/pop on both FIFOs.
- Pointers wrap modulo depth; counts are log2(depth)+1 bits and saturate at depth.

Optional Feature:
- Macro PIM_BUS_SLAVE_IRQ_EN. When defined, it adds:
  - Output o_irq (1 bit), registered, reset 0.
  - CTRL write bit8 = irq enable, reset 0.
  - Status readback [16] = irq enable.
  - o_irq = irq_en && (result FIFO non-empty || any sticky flag), updated each cycle.
- When undefined: no o_irq port, bit8 write ignored, status [16] reads 0.

Test Plan:
- Reset, then read PIM_CTRL with core idle -> next cycle o_bus_rd_data = 32'h0.
- Write 32'hDEAD_BEEF to 32'h4000_0043 (size 4'b1111), i_pim_cmd_ready = 0 -> o_pim_cmd_valid = 1, type = 0, sel = 3, data = 32'hDEAD_BEEF; CTRL read = 32'h0000_1001.
- Five activation writes to 32'h4000_0081 with ready low -> 4 queued, overflow set; CTRL read = 32'h0000_4005; raise ready -> 4 pops in order.
- Core pushes 32'h11, 32'h22; two PIM_R reads -> 32'h11 then 32'h22; third read -> 0, underflow set; CTRL = 32'h0000_0008.
- Result FIFO full + PIM_R read + i_pim_res_valid in the same cycle -> old head returned, count stays 4, new word lands at tail.
- Weight write with size 4'b0011 -> no push, status bit4 = 1; CTRL write 32'h3 -> flags and FIFOs cleared, CTRL read = 0; assert i_rst_n low mid-transfer -> all outputs at reset values immediately.
